nn_input_packer: RTL and testbench

Source-side front end for the classifier pipeline. It accepts a serial grayscale pixel stream over a valid/ready handshake and converts each pixel to signed fixed-point. It packs the pixels into the flat dataWidth*numInputs input vector and issues the one-cycle NNvalid strobe that starts layer 0. It sits between the image source (camera/UART/memory reader) and the network top.

---
 rtl/nn_input_packer.sv | 168 ++++++++++++++++
 tb/tb_nn_input_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_input_packer.sv
// nn_input_packer: converts a serial unsigned pixel stream to saturated signed fixed-point words and packs one frame into NNin.
// Latency: NNvalid one clock after the last accepted pixel; frameErr one clock after a bad-length beat.
// Backpressure: pixReady high only in FILL; low during the FIRE cycle (and in WAIT until nnDone when NN_PACKER_HOLD_EN is defined).
//
// Optional feature macro: NN_PACKER_HOLD_EN
//   defined   : FIRE -> WAIT; new pixels are refused until nnDone so NNin stays frozen
//               while the network computes.
//   undefined : FIRE -> FILL; pixReady returns the cycle after NNvalid, nnDone has no effect.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   pixIn     in   unsigned pixel value (pixWidth bits)
//   pixValid  in   pixIn/pixLast valid
//   pixLast   in   marks the final pixel of a frame
//   pixReady  out  packer can accept a pixel this cycle
//   nnDone    in   network finished the current frame
//   NNin      out  packed frame, pixel k at bits [dataWidth*k +: dataWidth]
//   NNvalid   out  one-cycle strobe: NNin holds a complete frame
//   frameErr  out  one-cycle strobe: frame length mismatch, frame discarded
//   pixCount  out  pixels accepted so far in the current frame

module nn_input_packer #(
    parameter int numInputs     = 784,
    parameter int dataWidth     = 16,
    parameter int dataFracWidth = 8,
    parameter int pixWidth      = 8,
    parameter int pixShift      = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [pixWidth-1:0]               pixIn,
    input  logic                              pixValid,
    input  logic                              pixLast,
    output logic                              pixReady,
    input  logic                              nnDone,
    output logic [dataWidth*numInputs-1:0]    NNin,
    output logic                              NNvalid,
    output logic                              frameErr,
    output logic [$clog2(numInputs+1)-1:0]    pixCount
);

    localparam int CNT_W  = $clog2(numInputs + 1);
    // Conversion is done in a width wide enough to hold the unsaturated shifted
    // pixel as well as the largest positive packed word.
    localparam int CONV_W = pixWidth + pixShift;
    localparam int EXT_W  = (CONV_W > dataWidth) ? CONV_W : dataWidth;
    localparam logic [EXT_W-1:0] MAX_POS  = EXT_W'({(dataWidth-1){1'b1}});
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(numInputs - 1);

    // The fractional width only documents the Q format of the packed word; the
    // conversion itself is fixed by pixShift. Reject formats that cannot hold
    // a sign bit.
    if (dataFracWidth >= dataWidth || numInputs < 1) begin : g_param_check
        $error("nn_input_packer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [CNT_W-1:0]               r_pix_count;
    logic                           r_frame_err;
    logic [dataWidth*numInputs-1:0] r_nnin;

    logic                           w_accept;
    logic                           w_at_last;
    logic                           w_complete;
    logic                           w_len_err;
    logic [EXT_W-1:0]               w_shifted;
    logic [dataWidth-1:0]           w_conv;

    // Ready depends on reset directly so it drops the instant reset asserts,
    // without waiting for the state register to settle.
    assign pixReady   = (r_state == ST_FILL) && reset;
    assign w_accept   = pixValid && pixReady;
    assign w_at_last  = (r_pix_count == LAST_IDX);
    assign w_complete = w_accept && w_at_last && pixLast;
    // Either an early pixLast or a missing pixLast on the final slot.
    assign w_len_err  = w_accept && (w_at_last != pixLast);

    // Pixel is unsigned, so the shifted value is never negative; only the
    // positive limit needs clamping.
    assign w_shifted  = EXT_W'(pixIn) << pixShift;
    assign w_conv     = (w_shifted > MAX_POS) ? MAX_POS[dataWidth-1:0]
                                              : w_shifted[dataWidth-1:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. nnDone is only looked at in WAIT, so a pulse during the
    // FIRE cycle (the cycle WAIT is entered) is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_complete) begin
                    w_state_nxt = ST_FIRE;
                end
            end
            ST_FIRE: begin
`ifdef NN_PACKER_HOLD_EN
                w_state_nxt = ST_WAIT;
`else
                w_state_nxt = ST_FILL;
`endif
            end
            ST_WAIT: begin
                if (nnDone) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // Pixel counter: any beat carrying pixLast or filling the final slot ends
    // the frame, whether it completed cleanly or in error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix_count <= '0;
        end else if (w_accept) begin
            if (w_at_last || pixLast) begin
                r_pix_count <= '0;
            end else begin
                r_pix_count <= r_pix_count + 1'b1;
            end
        end
    end

    // Error strobe, one cycle after the offending beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_len_err;
        end
    end

    // Frame buffer: each accepted beat lands straight in its slice. No beat is
    // accepted outside FILL, so the frame is stable from NNvalid until the
    // first pixel of the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nnin <= '0;
        end else if (w_accept) begin
            r_nnin[int'(r_pix_count)*dataWidth +: dataWidth] <= w_conv;
        end
    end

    assign NNin     = r_nnin;
    assign NNvalid  = (r_state == ST_FIRE);
    assign frameErr = r_frame_err;
    assign pixCount = r_pix_count;

endmodule

// File: tb/tb_nn_input_packer.sv
// tb_nn_input_packer: two packers (pixShift 5 and 8, numInputs 4) share one stimulus stream.
// Latency: outputs compared on every falling edge against a frame-level reference model.
// Backpressure: the model decides acceptance from its own notion of readiness.

module tb_nn_input_packer;

    localparam int NI = 4;
    localparam int DW = 16;
    localparam int CW = $clog2(NI + 1);

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      pix_in;
    logic            pix_vld;
    logic            pix_last;
    logic            nn_done;

    logic            rdy_a, vld_a, err_a;
    logic            rdy_b, vld_b, err_b;
    logic [DW*NI-1:0] nnin_a, nnin_b;
    logic [CW-1:0]   cnt_a, cnt_b;

    nn_input_packer #(.numInputs(NI), .dataWidth(DW), .dataFracWidth(8),
                      .pixWidth(8), .pixShift(5)) dut_a (
        .clk(clk), .reset(reset), .pixIn(pix_in), .pixValid(pix_vld),
        .pixLast(pix_last), .pixReady(rdy_a), .nnDone(nn_done),
        .NNin(nnin_a), .NNvalid(vld_a), .frameErr(err_a), .pixCount(cnt_a)
    );

    nn_input_packer #(.numInputs(NI), .dataWidth(DW), .dataFracWidth(8),
                      .pixWidth(8), .pixShift(8)) dut_b (
        .clk(clk), .reset(reset), .pixIn(pix_in), .pixValid(pix_vld),
        .pixLast(pix_last), .pixReady(rdy_b), .nnDone(nn_done),
        .NNin(nnin_b), .NNvalid(vld_b), .frameErr(err_b), .pixCount(cnt_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int          m_frame[$];      // raw pixels of the frame being collected
    bit          m_ready;
    bit          m_fire;
    bit          m_err;
    bit          m_hold;
    bit          m_known;         // expected NNin is defined
    logic [63:0] m_exp_a;
    logic [63:0] m_exp_b;

    function automatic int conv(input int p, input int sh);
        int v;
        v = p * (1 << sh);
        return (v > 32767) ? 32767 : v;
    endfunction

    function automatic logic [63:0] pack(input int sh);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < NI; k++) begin
            r[16*k +: 16] = 16'(conv(m_frame[k], sh));
        end
        return r;
    endfunction

    task automatic model_reset();
        m_frame.delete();
        m_ready = 1'b1;
        m_fire  = 1'b0;
        m_err   = 1'b0;
        m_hold  = 1'b0;
        m_known = 1'b1;
        m_exp_a = '0;
        m_exp_b = '0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input bit v, input bit l, input int p, input bit d);
        bit acc;
        bit fired;
        acc    = v && m_ready;
        fired  = m_fire;
        m_fire = 1'b0;
        m_err  = 1'b0;
        if (fired) begin
`ifdef NN_PACKER_HOLD_EN
            m_hold  = 1'b1;
            m_ready = 1'b0;
`else
            m_ready = 1'b1;
`endif
        end else if (m_hold) begin
            if (d) begin
                m_hold  = 1'b0;
                m_ready = 1'b1;
            end
        end else if (acc) begin
            m_frame.push_back(p);
            m_known = 1'b0;
            if (m_frame.size() == NI || l) begin
                if (m_frame.size() == NI && l) begin
                    m_fire  = 1'b1;
                    m_ready = 1'b0;
                    m_exp_a = pack(5);
                    m_exp_b = pack(8);
                    m_known = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_frame.delete();
            end
        end
    endtask

    task automatic check_all();
        check("pixReady_a", rdy_a, m_ready);
        check("pixReady_b", rdy_b, m_ready);
        check("NNvalid_a", vld_a, m_fire);
        check("NNvalid_b", vld_b, m_fire);
        check("frameErr_a", err_a, m_err);
        check("frameErr_b", err_b, m_err);
        check("excl_a", vld_a & err_a, 0);
        check("pixCount_a", cnt_a, m_frame.size());
        check("pixCount_b", cnt_b, m_frame.size());
        if (m_known) begin
            check("NNin_a", nnin_a, m_exp_a);
            check("NNin_b", nnin_b, m_exp_b);
        end
    endtask

    // One clock: drive after the falling edge, compare at the next falling edge.
    task automatic cycle(input bit v, input bit l, input int p, input bit d);
        pix_vld  = v;
        pix_last = l;
        pix_in   = p[7:0];
        nn_done  = d;
        model_edge(v, l, p, d);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},  rdy_a,  0);
        check({tag, "_vld"},  vld_a,  0);
        check({tag, "_err"},  err_a,  0);
        check({tag, "_nnin"}, nnin_a, 0);
        check({tag, "_cnt"},  cnt_a,  0);
        check({tag, "_rdyb"}, rdy_b,  0);
    endtask

    int pulses;
    int lsel;

    initial begin
        reset    = 1'b0;
        pix_vld  = 1'b0;
        pix_last = 1'b0;
        pix_in   = '0;
        nn_done  = 1'b0;
        model_reset();

        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all();

        // Basic frame, pixValid held high across the strobe.
        cycle(1, 0, 255, 0);
        cycle(1, 0, 0,   0);
        cycle(1, 0, 128, 0);
        cycle(1, 1, 1,   0);
        check("tp_valid", vld_a, 1);
        check("tp_nnin_a", nnin_a, 64'h0020_1000_0000_1FE0);
        check("tp_nnin_b", nnin_b, 64'h0100_7FFF_0000_7FFF);
        check("tp_cnt", cnt_a, 0);

        // Idle through the hold window, then release with nnDone.
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        check("post_done_rdy", rdy_a, 1);

        // Mid-range pixel with the large shift.
        cycle(1, 0, 127, 0);
        cycle(1, 0, 127, 0);
        cycle(1, 0, 127, 0);
        cycle(1, 1, 127, 0);
        check("tp_127_b", nnin_b, 64'h7F00_7F00_7F00_7F00);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // Early pixLast, then a clean frame.
        cycle(1, 0, 10, 0);
        cycle(1, 1, 20, 0);
        check("early_last_err", err_a, 1);
        check("early_last_vld", vld_a, 0);
        cycle(1, 0, 3, 0);
        cycle(1, 0, 7, 0);
        cycle(1, 0, 9, 0);
        cycle(1, 1, 200, 0);
        check("clean_after_err", vld_a, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // Missing pixLast on the fourth pixel.
        cycle(1, 0, 1, 0);
        cycle(1, 0, 2, 0);
        cycle(1, 0, 3, 0);
        cycle(1, 0, 4, 0);
        check("missing_last_err", err_a, 1);
        check("missing_last_vld", vld_a, 0);

        // Asynchronous reset with two pixels collected.
        cycle(1, 0, 5, 0);
        cycle(1, 0, 6, 0);
        check("pre_reset_cnt", cnt_a, 2);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        pulses = 0;
        cycle(1, 0, 1, 0); pulses += int'(vld_a);
        cycle(1, 0, 2, 0); pulses += int'(vld_a);
        cycle(1, 0, 3, 0); pulses += int'(vld_a);
        cycle(1, 1, 4, 0); pulses += int'(vld_a);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1);
            pulses += int'(vld_a);
        end
        check("one_strobe", pulses, 1);

        // Randomized traffic, mostly well-formed frames.
        for (int i = 0; i < 3000; i++) begin
            bit v, l, d;
            int p;
            v    = ($urandom_range(0, 3) != 0);
            lsel = $urandom_range(0, 7);
            p    = (lsel == 0) ? 0 : (lsel == 1) ? 255 : int'($urandom_range(0, 255));
            if (m_frame.size() == NI - 1) l = ($urandom_range(0, 9) != 0);
            else                          l = ($urandom_range(0, 19) == 0);
            d = ($urandom_range(0, 3) == 0);
            cycle(v, l, p, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
